// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: oversample tick, bit tick and bit-centre tick
// derived from a table or custom D + F/2^FRAC_W clock divisor.
module baud_gen_frac #(
  parameter int unsigned CNT_W      = 14,
  parameter int unsigned FRAC_W     = 4,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [2:0]        baud_select,
  input  logic              use_custom,
  input  logic              div_load,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              resync,
  output logic              sample_enable,
  output logic              bit_tick,
  output logic              mid_tick
);

  localparam int unsigned PH_W = $clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(26);

  // Divisor table for a 50 MHz clock at 16x oversampling.
  function automatic logic [CNT_W-1:0] table_div(input logic [2:0] sel);
    logic [CNT_W-1:0] d;
    case (sel)
      3'd0:    d = CNT_W'(10416);
      3'd1:    d = CNT_W'(2603);
      3'd2:    d = CNT_W'(650);
      3'd3:    d = CNT_W'(325);
      3'd4:    d = CNT_W'(162);
      3'd5:    d = CNT_W'(80);
      3'd6:    d = CNT_W'(53);
      default: d = CNT_W'(26);
    endcase
    return d;
  endfunction

  logic [CNT_W-1:0]  cust_int_q, cust_int_d;
  logic [FRAC_W-1:0] cust_frac_q, cust_frac_d;
  logic [CNT_W-1:0]  pend_int_q, pend_int_d;
  logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ext_q, ext_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              se_q, se_d;
  logic              bit_q, bit_d;
  logic              mid_q, mid_d;
  logic [FRAC_W:0]   acc_sum;

  // ext_q holds the one-cycle carry extension so the counter never needs D+1.
  always_comb begin
    cust_int_d  = cust_int_q;
    cust_frac_d = cust_frac_q;
    cnt_d       = cnt_q;
    ext_d       = ext_q;
    acc_d       = acc_q;
    phase_d     = phase_q;
    se_d        = 1'b0;
    bit_d       = 1'b0;
    mid_d       = 1'b0;
    acc_sum     = {1'b0, acc_q} + {1'b0, pend_frac_q};

    if (div_load) begin
      cust_int_d  = div_int;
      cust_frac_d = div_frac;
    end
    pend_int_d  = use_custom ? cust_int_q : table_div(baud_select);
    pend_frac_d = use_custom ? cust_frac_q : '0;

    if (resync) begin
      cnt_d   = pend_int_q;
      ext_d   = 1'b0;
      acc_d   = '0;
      phase_d = '0;
    end else if (enable) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else if (ext_q) begin
        ext_d = 1'b0;
      end else begin
        se_d    = 1'b1;
        bit_d   = (phase_q == PH_LAST);
        mid_d   = (phase_q == PH_MID);
        phase_d = phase_q + PH_W'(1);
        acc_d   = acc_sum[FRAC_W-1:0];
        ext_d   = acc_sum[FRAC_W];
        cnt_d   = pend_int_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cust_int_q  <= '0;
      cust_frac_q <= '0;
      pend_int_q  <= RST_DIV;
      pend_frac_q <= '0;
      cnt_q       <= RST_DIV;
      ext_q       <= 1'b0;
      acc_q       <= '0;
      phase_q     <= '0;
      se_q        <= 1'b0;
      bit_q       <= 1'b0;
      mid_q       <= 1'b0;
    end else begin
      cust_int_q  <= cust_int_d;
      cust_frac_q <= cust_frac_d;
      pend_int_q  <= pend_int_d;
      pend_frac_q <= pend_frac_d;
      cnt_q       <= cnt_d;
      ext_q       <= ext_d;
      acc_q       <= acc_d;
      phase_q     <= phase_d;
      se_q        <= se_d;
      bit_q       <= bit_d;
      mid_q       <= mid_d;
    end
  end

  assign sample_enable = se_q;
  assign bit_tick      = bit_q;
  assign mid_tick      = mid_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Scoreboard bench for baud_gen_frac: stimulus queues expected tick spacing and
// phase flags; a negedge monitor measures each tick against the queue head.
module tb_baud_gen_frac;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [2:0]  baud_select;
  logic        use_custom;
  logic        div_load;
  logic [13:0] div_int;
  logic [3:0]  div_frac;
  logic        resync;
  logic        sample_enable;
  logic        bit_tick;
  logic        mid_tick;

  baud_gen_frac #(.CNT_W(14), .FRAC_W(4), .OVERSAMPLE(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .baud_select  (baud_select),
    .use_custom   (use_custom),
    .div_load     (div_load),
    .div_int      (div_int),
    .div_frac     (div_frac),
    .resync       (resync),
    .sample_enable(sample_enable),
    .bit_tick     (bit_tick),
    .mid_tick     (mid_tick)
  );

  typedef struct {
    int   gap;
    logic bt;
    logic md;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   mark = 0;
  int   ph = 0;
  logic chk_en = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // gap = cycles since previous tick, or since the edge after a mark.
  initial begin
    int gap;
    int last_mark;
    int idx;
    exp_t e;
    gap = 0;
    last_mark = 0;
    idx = 0;
    forever begin
      @(negedge clk);
      gap++;
      if (!rst) begin
        tests++;
        if ({sample_enable, bit_tick, mid_tick} != 3'b000) begin
          fails++;
          $display("FAIL reset_outputs: got se/bit/mid=%b%b%b, want 000", sample_enable, bit_tick, mid_tick);
        end
      end else begin
        if (!sample_enable && (bit_tick || mid_tick)) begin
          tests++;
          fails++;
          $display("FAIL stray_tick: bit=%b mid=%b without sample_enable", bit_tick, mid_tick);
        end
        if (sample_enable) begin
          if (chk_en) begin
            tests++;
            if (q.size() == 0) begin
              fails++;
              $display("FAIL unexpected_tick: got tick gap=%0d, want none", gap);
            end else begin
              e = q.pop_front();
              idx++;
              if (gap != e.gap || bit_tick != e.bt || mid_tick != e.md) begin
                fails++;
                $display("FAIL tick%0d: got gap=%0d bit=%b mid=%b, want gap=%0d bit=%b mid=%b",
                         idx, gap, bit_tick, mid_tick, e.gap, e.bt, e.md);
              end
            end
          end
          gap = 0;
        end
      end
      if (mark != last_mark) begin
        last_mark = mark;
        gap = -1;
      end
    end
  end

  task automatic push_tick(input int g);
    exp_t e;
    e.gap = g;
    e.bt  = (ph == 15);
    e.md  = (ph == 7);
    q.push_back(e);
    ph = (ph + 1) % 16;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget, input string name);
    for (int i = 0; i < budget && q.size() != 0; i++) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d ticks outstanding, want 0", name, q.size());
      q.delete();
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; enable = 1'b1; baud_select = 3'b111; use_custom = 1'b0;
    div_load = 1'b0; div_int = '0; div_frac = '0; resync = 1'b0;
    #2 rst = 1'b0;

    // Reset release at 111: 27-cycle ticks, bit every 16, mid on the 8th.
    step(4);
    mark++;
    ph = 0;
    for (int i = 0; i < 32; i++) push_tick(27);
    step(1);
    rst = 1'b1;
    chk_en = 1'b1;
    drain(32 * 27 + 100, "reset_run");

    // Resync landing in the count-0 cycle: tick suppressed, phase restarts.
    chk_en = 1'b0;
    n = 0;
    step(1);
    while (!sample_enable && n < 100) begin
      step(1);
      n++;
    end
    step(26);
    resync = 1'b1;
    mark++;
    ph = 0;
    for (int i = 0; i < 16; i++) push_tick(27);
    step(1);
    resync = 1'b0;
    chk_en = 1'b1;
    drain(16 * 27 + 100, "resync");

    // Ten-cycle enable pause stretches one period to 37.
    push_tick(37);
    push_tick(27);
    step(5);
    enable = 1'b0;
    step(10);
    enable = 1'b1;
    drain(200, "pause");

    // 111 -> 000 mid-period: current period completes, next is 10417.
    push_tick(27);
    push_tick(10417);
    step(3);
    baud_select = 3'b000;
    drain(10417 + 200, "rate_change");

    // Mid-period reset, then custom D=2 F=8 loaded: 27 then 3,4,3,4...
    chk_en = 1'b0;
    baud_select = 3'b111;
    step(50);
    rst = 1'b0;
    step(3);
    mark++;
    ph = 0;
    push_tick(27);
    for (int i = 0; i < 20; i++) push_tick((i % 2 == 0) ? 3 : 4);
    step(1);
    rst = 1'b1;
    use_custom = 1'b1;
    div_int = 14'd2;
    div_frac = 4'd8;
    div_load = 1'b1;
    chk_en = 1'b1;
    step(1);
    div_load = 1'b0;
    drain(27 + 20 * 4 + 100, "custom_frac");

    // Custom D=0 F=0 after resync: tick every cycle, bit every 16.
    chk_en = 1'b0;
    div_int = '0;
    div_frac = '0;
    div_load = 1'b1;
    step(1);
    div_load = 1'b0;
    step(3);
    resync = 1'b1;
    mark++;
    ph = 0;
    for (int i = 0; i < 40; i++) push_tick(1);
    step(1);
    resync = 1'b0;
    chk_en = 1'b1;
    drain(100, "div_zero");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/baud_gen_frac.md
BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Interface
REQ-001 Parameter CNT_W, default 14: width of the divisor integer part and of the down-counter.
REQ-002 Parameter FRAC_W, default 4: width of the divisor fractional part and of the phase accumulator.
REQ-003 Parameter OVERSAMPLE, default 16: sample ticks per bit; a power of two, minimum 4.
REQ-004 clk  input  1  sole clock; all state on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  high = generator runs.
REQ-007 baud_select  input  3  table rate select, used when use_custom=0.
REQ-008 use_custom  input  1  1 = use the custom divisor registers instead of the table.
REQ-009 div_load  input  1  one-cycle strobe; captures div_int/div_frac into the custom pending registers.
REQ-010 div_int  input  CNT_W  custom integer divisor D.
REQ-011 div_frac  input  FRAC_W  custom fractional divisor F, in units of 1/2^FRAC_W cycle.
REQ-012 resync  input  1  one-cycle strobe; realigns tick phase (RX start-bit edge).
REQ-013 sample_enable  output  1  one-cycle oversample tick, registered.
REQ-014 bit_tick  output  1  one-cycle tick once per OVERSAMPLE sample ticks, registered.
REQ-015 mid_tick  output  1  one-cycle tick at the bit centre, registered.

Function
REQ-016 Table divisors for baud_select 000..111 SHALL be D = 10416, 2603, 650, 325, 162, 80, 53, 26 with F=0 (50 MHz clock, 16x oversampling).
REQ-017 Sample period SHALL be D+1 clk cycles, plus one extra cycle in each period where the fractional accumulator carries.
REQ-018 The down-counter SHALL load the active D (+1 on carry) and decrement each enabled cycle; at count 0 sample_enable SHALL be 1 for that cycle only, and the counter SHALL reload.
REQ-019 At each reload the FRAC_W-bit accumulator SHALL add F modulo 2^FRAC_W; the carry-out SHALL extend the next period by one cycle.
REQ-020 Divisor changes (baud_select, use_custom, div_load) SHALL update pending registers only; the active D/F SHALL be taken from pending at the next reload, never mid-period.
REQ-021 D=0 SHALL give sample_enable on every enabled cycle (with F=0).
REQ-022 A phase counter of log2(OVERSAMPLE) bits SHALL increment on each sample_enable, wrapping OVERSAMPLE-1 to 0.
REQ-023 bit_tick SHALL assert with the sample_enable that takes phase from OVERSAMPLE-1 to 0.
REQ-024 mid_tick SHALL assert with the sample_enable that takes phase from OVERSAMPLE/2-1 to OVERSAMPLE/2.
REQ-025 resync SHALL reload the counter from pending D/F, clear the phase counter and accumulator, and suppress all ticks that cycle; the first sample_enable after it SHALL come D+1 cycles later.
REQ-026 resync coinciding with count 0 SHALL take priority: no tick is emitted.
REQ-027 enable=0 SHALL hold counter, phase and accumulator at their values and force all ticks to 0; on re-enable counting resumes from the held value.
REQ-028 div_load coinciding with a reload SHALL be captured and take effect at the following reload.

Reset
REQ-029 On rst=0 all ticks SHALL be 0; phase and accumulator 0; pending and active divisors set to table entry 111 (D=26, F=0); counter loaded with 26; custom pending registers 0.
REQ-030 Reset asserted mid-period SHALL act immediately; after release the first sample_enable SHALL come 27 enabled cycles later, with the divisor selected by the current inputs taking effect at the following reload.

Verification
REQ-031 Reset release, baud_select=111, enable=1 -> sample_enable every 27 cycles; bit_tick every 432; mid_tick 216 cycles after each bit_tick.
REQ-032 use_custom=1, div_load with D=2, F=8 -> periods alternate 3,4,3,4 cycles from the second reload onward.
REQ-033 baud_select 111->000 mid-period -> current 27-cycle period completes, next period 10417 cycles.
REQ-034 resync in the cycle of count 0 -> no tick; next sample_enable 27 cycles later with phase 0, mid_tick on the 8th tick.
REQ-035 enable low for 10 cycles mid-period -> no ticks; period containing the pause measures 37 cycles.
REQ-036 Custom D=0, F=0 -> sample_enable every cycle, bit_tick every 16 cycles.
